// File: rtl/clz_pipe.sv
// Pipelined leading-zero / redundant-sign-bit counter with valid/ready on both sides.
// Optional normalised-operand output when CLZ_NORM_EN is defined.
module clz_pipe #(
  parameter int WIDTH   = 32,
  parameter int GROUP   = 8,
  parameter int LATENCY = 2,
  parameter int CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
`ifdef CLZ_NORM_EN
  output logic [WIDTH-1:0] out_norm,
`endif
  output logic             out_zero
);

  localparam int NG = WIDTH / GROUP;
  localparam int LW = $clog2(GROUP+1);

  typedef logic [NG-1:0][LW-1:0] lc_t;

  function automatic logic [LW-1:0] grp_clz(
    input logic [GROUP-1:0] v
  );
    logic [LW-1:0] n;
    logic          done;
    n    = '0;
    done = 1'b0;
    for (int i = GROUP-1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n = n + LW'(1);
      end
    end
    return n;
  endfunction

  // MSB-most non-empty group wins; signed mode caps at WIDTH-1
  function automatic logic [CW-1:0] combine(
    input logic [NG-1:0] gz,
    input lc_t           lc,
    input logic          sgn
  );
    logic [CW-1:0] c;
    logic          found;
    c     = CW'(WIDTH);
    found = 1'b0;
    for (int g = NG-1; g >= 0; g--) begin
      if (!found && !gz[g]) begin
        found = 1'b1;
        c = CW'((NG-1-g)*GROUP) + CW'(lc[g]);
      end
    end
    if (sgn && c > CW'(WIDTH-1))
      c = CW'(WIDTH-1);
    return c;
  endfunction

  logic [WIDTH-1:0] x;
  logic [NG-1:0]    gz_c;
  lc_t              lc_c;
  logic             zero_c;

  always_comb begin
    x = in_data;
    if (in_signed)
      x = (in_data ^ {WIDTH{in_data[WIDTH-1]}}) << 1;
    zero_c = (in_data == '0);
    for (int g = 0; g < NG; g++) begin
      gz_c[g] = ~|x[g*GROUP +: GROUP];
      lc_c[g] = grp_clz(x[g*GROUP +: GROUP]);
    end
  end

  generate
    if (LATENCY == 2) begin : g_l2
      logic          s1_valid;
      logic          s1_sgn;
      logic          s1_zero;
      logic [NG-1:0] s1_gz;
      lc_t           s1_lc;
      logic          s1_adv;
      logic          out_ld;
      logic [CW-1:0] cnt;
`ifdef CLZ_NORM_EN
      logic [WIDTH-1:0] s1_data;
`endif

      assign out_ld   = !out_valid || out_ready;
      assign s1_adv   = s1_valid && out_ld;
      assign in_ready = !s1_valid || s1_adv;
      assign cnt      = combine(s1_gz, s1_lc, s1_sgn);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_valid <= 1'b0;
          s1_sgn   <= 1'b0;
          s1_zero  <= 1'b0;
          s1_gz    <= '0;
          s1_lc    <= '0;
`ifdef CLZ_NORM_EN
          s1_data  <= '0;
`endif
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_sgn  <= in_signed;
            s1_zero <= zero_c;
            s1_gz   <= gz_c;
            s1_lc   <= lc_c;
`ifdef CLZ_NORM_EN
            s1_data <= in_data;
`endif
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          out_count <= '0;
          out_zero  <= 1'b0;
`ifdef CLZ_NORM_EN
          out_norm  <= '0;
`endif
        end else if (out_ld) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_count <= cnt;
            out_zero  <= s1_zero;
`ifdef CLZ_NORM_EN
            out_norm  <= s1_data << cnt;
`endif
          end
        end
      end
    end else begin : g_l1
      logic [CW-1:0] cnt;

      assign in_ready = !out_valid || out_ready;
      assign cnt      = combine(gz_c, lc_c, in_signed);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid <= 1'b0;
          out_count <= '0;
          out_zero  <= 1'b0;
`ifdef CLZ_NORM_EN
          out_norm  <= '0;
`endif
        end else if (in_ready) begin
          out_valid <= in_valid;
          if (in_valid) begin
            out_count <= cnt;
            out_zero  <= zero_c;
`ifdef CLZ_NORM_EN
            out_norm  <= in_data << cnt;
`endif
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_clz_pipe.sv
// Bench for clz_pipe: 32-bit/2-stage instance with scoreboard,
// plus a 16-bit/1-stage instance swept with a walking one.
module tb_clz_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_sgn, a_ovalid, a_oready, a_zero;
  logic [31:0] a_data;
  logic [5:0]  a_cnt;
  logic        b_valid, b_ready, b_ovalid, b_oready, b_zero;
  logic [15:0] b_data;
  logic [4:0]  b_cnt;
`ifdef CLZ_NORM_EN
  logic [31:0] a_norm;
  logic [15:0] b_norm;
`endif

  clz_pipe #(.WIDTH(32), .GROUP(8), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_signed(a_sgn),
    .out_valid(a_ovalid), .out_ready(a_oready),
    .out_count(a_cnt),
`ifdef CLZ_NORM_EN
    .out_norm(a_norm),
`endif
    .out_zero(a_zero)
  );

  clz_pipe #(.WIDTH(16), .GROUP(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_signed(1'b0),
    .out_valid(b_ovalid), .out_ready(b_oready),
    .out_count(b_cnt),
`ifdef CLZ_NORM_EN
    .out_norm(b_norm),
`endif
    .out_zero(b_zero)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: length of the leading run equal to the top bit
  // (or to 0 in unsigned mode), minus the sign bit itself.
  function automatic int ref_cnt(input logic [63:0] d,
                                 input int w, input bit s);
    int n;
    logic lead;
    n = 0;
    lead = s ? d[w-1] : 1'b0;
    for (int i = w-1; i >= 0; i--) begin
      if (d[i] != lead) break;
      n++;
    end
    return s ? n-1 : n;
  endfunction

  typedef struct {
    int          cnt;
    bit          z;
    logic [31:0] norm;
    int          cyc;
    bit          dir;
    int          dc;
    bit          dz;
    logic [31:0] dn;
  } exp_t;

  exp_t q[$];
  exp_t me, mo;
  int   cyc = 0;
  int   acc = 0;
  bit   lat_strict = 0;
  bit   hold = 0;
  logic [5:0]  h_cnt;
  logic        h_zero;
  logic [31:0] h_norm;
  bit          c_dir = 0;
  int          c_dc = 0;
  bit          c_dz = 0;
  logic [31:0] c_dn = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      hold = 0;
    end else begin
      if (hold && a_ovalid) begin
        check("hold_count", a_cnt, h_cnt);
        check("hold_zero", a_zero, h_zero);
`ifdef CLZ_NORM_EN
        check("hold_norm", a_norm, h_norm);
`endif
      end
      if (a_ovalid && a_oready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mo = q.pop_front();
          check("count", a_cnt, mo.cnt);
          check("zero", a_zero, mo.z);
`ifdef CLZ_NORM_EN
          check("norm", a_norm, mo.norm);
`endif
          if (mo.dir) begin
            check("dir_count", a_cnt, mo.dc);
            check("dir_zero", a_zero, mo.dz);
`ifdef CLZ_NORM_EN
            check("dir_norm", a_norm, mo.dn);
`endif
          end
          if (lat_strict)
            check("latency", cyc - mo.cyc, 2);
        end
      end
      hold   = a_ovalid && !a_oready;
      h_cnt  = a_cnt;
      h_zero = a_zero;
`ifdef CLZ_NORM_EN
      h_norm = a_norm;
`endif
      if (a_valid && a_ready) begin
        me.cnt  = ref_cnt({32'd0, a_data}, 32, a_sgn);
        me.z    = (a_data == 32'd0);
        me.norm = a_data << me.cnt;
        me.cyc  = cyc;
        me.dir  = c_dir;
        me.dc   = c_dc;
        me.dz   = c_dz;
        me.dn   = c_dn;
        q.push_back(me);
        acc++;
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit s,
                      input bit dir, input int dc,
                      input bit dz, input logic [31:0] dn);
    a_valid = 1'b1;
    a_data  = d;
    a_sgn   = s;
    c_dir = dir; c_dc = dc; c_dz = dz; c_dn = dn;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (a_ready) break;
      if (t == 99) check("send_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    c_dir   = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++)
      @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_op(input bit s);
    logic [31:0] d;
    d = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) d = '0;
    if (s && $urandom_range(0, 1) == 1) d = ~d;
    return d;
  endfunction

  bit rnd_done;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    a_valid = 0; a_data = '0; a_sgn = 0; a_oready = 1;
    b_valid = 0; b_data = '0; b_oready = 1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ovalid", a_ovalid, 0);
    check("rst_iready", a_ready, 1);
    check("rst_count", a_cnt, 0);
    check("rst_zero", a_zero, 0);
    check("rst_b_ovalid", b_ovalid, 0);
`ifdef CLZ_NORM_EN
    check("rst_norm", a_norm, 0);
`endif
    @(posedge clk);
    #1;

    lat_strict = 1;
    send(32'h80000000, 0, 1, 0, 0, 32'h80000000);
    send(32'h00000001, 0, 1, 31, 0, 32'h80000000);
    send(32'h00010000, 0, 1, 15, 0, 32'h80000000);
    send(32'h00000000, 0, 1, 32, 1, 32'h00000000);
    drain();

    send(32'hFFFFFFFF, 1, 1, 31, 0, 32'h80000000);
    send(32'hFFFF8000, 1, 1, 16, 0, 32'h80000000);
    send(32'h00004000, 1, 1, 16, 0, 32'h40000000);
    send(32'h7FFFFFFF, 1, 1, 0, 0, 32'h7FFFFFFF);
    drain();

    send(32'h00012345, 0, 1, 15, 0, 32'h91A28000);
    send(32'h00000000, 1, 1, 31, 1, 32'h00000000);
    drain();
    lat_strict = 0;

    a_oready = 1'b0;
    acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h00100000 >> i, 0, 0, 0, 0, '0);
      end
      begin
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("bp_accepted", acc, 2);
        check("bp_iready", a_ready, 0);
        @(posedge clk);
        #1 a_oready = 1'b1;
      end
    join
    drain();

    a_oready = 1'b0;
    send(32'h0000FFFF, 0, 0, 0, 0, '0);
    send(32'h000000FF, 0, 0, 0, 0, '0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ovalid", a_ovalid, 0);
    check("arst_count", a_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    a_oready = 1'b1;
    @(negedge clk);
    check("arst_iready", a_ready, 1);
    check("arst_ovalid_rel", a_ovalid, 0);
    repeat (5) @(negedge clk);
    check("arst_no_stale", a_ovalid, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = (i < 16) ? (16'h8000 >> i) : 16'h0000;
      #1;
      check("l1_iready", b_ready, 1);
      @(posedge clk);
      #1 b_valid = 1'b0;
      @(negedge clk);
      check("l1_ovalid", b_ovalid, 1);
      check("l1_count", b_cnt, i);
      check("l1_zero", b_zero, (i == 16));
`ifdef CLZ_NORM_EN
      check("l1_norm", b_norm, (i < 16) ? 16'h8000 : 16'h0000);
`endif
    end
    @(posedge clk);
    #1;

    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          a_sgn = $urandom_range(0, 1);
          send(rnd_op(a_sgn), a_sgn, 0, 0, 0, '0);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 a_oready = ($urandom_range(0, 2) != 0);
        end
        a_oready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clz_pipe.md
Name: clz_pipe

Overview:
- Parametrised, pipelined successor to the fixed 31-bit combinational leading-zero priority encoder.
- Counts leading zeros (unsigned mode) or redundant sign bits (signed mode) of a WIDTH-bit operand.
- Explicit all-zero flag; no undefined count for a zero input.
- Valid/ready handshake on both sides. Sits between the iteration datapath and the fixed-point normalisation/escape logic of the Mandelbrot core.

Parameters:
- WIDTH, 32, operand width; 8..64.
- GROUP, 8, bits per first-level encoder group; must divide WIDTH.
- LATENCY, 2, register stages from accepted input to out_valid; legal values 1 or 2.
- CW, $clog2(WIDTH+1), count width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block accepts operand this cycle
- in_data  input  WIDTH  operand
- in_signed  input  1  1 = redundant-sign-bit mode, 0 = leading-zero mode
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_count  output  CW  result count
- out_zero  output  1  operand was all zeros
- out_norm  output  WIDTH  normalised operand (only with CLZ_NORM_EN)

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, so out_valid = 0. out_count, out_zero and out_norm = 0. in_ready = 1 in the first cycle after release.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_* must be held stable while out_valid && !out_ready.
- Pipeline advance:
  - Each stage register loads when it is empty or its contents move on this cycle.
  - in_ready = !s1_valid || s1_advance, where s1_advance is true when s1 moves on this cycle.
  - No combinational path from in_valid to in_ready.
  - Throughput is 1 result per cycle while out_ready = 1.
  - Results emerge in input order, none dropped or duplicated.
- Latency: result appears LATENCY cycles after the input transfer when there is no back-pressure.
- LATENCY = 2:
  - Stage 1 registers, per GROUP: group-all-zero flag and local leading-zero count of the pre-processed operand.
  - Stage 2: the first non-zero group (MSB side) selects count = group_index*GROUP + local_count.
- LATENCY = 1: full encode in one stage; output is registered.
- Unsigned mode (in_signed = 0):
  - out_count = number of consecutive 0 bits from bit WIDTH-1 downward; range 0..WIDTH.
  - in_data = 0 gives out_count = WIDTH, out_zero = 1.
- Signed mode (in_signed = 1):
  - Operand pre-processed as x = in_data XOR {WIDTH{in_data[WIDTH-1]}}, shifted left by 1 with 0 fill into bit 0.
  - out_count = CLZ(x) capped at WIDTH-1, i.e. the redundant sign bits.
  - All-zeros and all-ones operands both give out_count = WIDTH-1.
  - out_zero = 1 only when in_data = 0.
- out_zero is independent of mode: 1 iff in_data = 0.
- Back-pressure with a full pipeline: in_ready = 0 until out_ready = 1. No state changes while stalled.
- Reset asserted mid-operation: all in-flight results discarded; no partial result is output after release.

Optional Feature:
- Macro: CLZ_NORM_EN.
- Defined:
  - out_norm = in_data shifted left by out_count, zero fill, carried through the pipeline aligned with its count.
  - For LATENCY = 2, the operand is registered in stage 1 and shifted in stage 2.
  - in_data = 0 gives out_norm = 0.
- Undefined:
  - out_norm port and its registers are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=32, LATENCY=2, unsigned; in_data = 0x80000000, 0x00000001, 0x00010000, 0x00000000 back-to-back, out_ready = 1 → out_count 0, 31, 15, 32. out_zero only on the 4th result. First out_valid 2 cycles after the first transfer; one result per cycle.
- Signed mode; in_data = 0xFFFFFFFF, 0xFFFF8000, 0x00004000, 0x7FFFFFFF → out_count 31, 16, 16, 0; out_zero = 0 for all four.
- Back-pressure: stream 6 operands, hold out_ready = 0 for 5 cycles → in_ready = 0 after 2 operands accepted (LATENCY=2). out_* stable during the stall. After release all 6 results arrive in order, no loss or duplication.
- Reset: drop reset_n while 2 results are in flight → out_valid = 0 immediately (async). After release no stale result appears; in_ready = 1.
- LATENCY=1, WIDTH=16, GROUP=4; sweep a single 1 across bits 15..0 plus zero → counts 0..15 then 16, each 1 cycle after acceptance.
- CLZ_NORM_EN defined; in_data = 0x00012345, unsigned → out_count 15, out_norm = 0x91A28000. in_data = 0 → out_norm = 0.
